// File: rtl/midi_pkg.sv
// rtl/midi_pkg.sv - shared constants and state encoding for the MIDI note parser
package midi_pkg;

  // Channel voice status nibbles
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CH_AT    = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // Byte-class boundaries: [F0,F8) system common, [F8,FF] realtime
  localparam logic [7:0] COMMON_BASE   = 8'hF0;
  localparam logic [7:0] REALTIME_BASE = 8'hF8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } parse_state_e;

endpackage

// File: rtl/midi_byte_classify.sv
// rtl/midi_byte_classify.sv - combinational MIDI byte classifier
module midi_byte_classify
  import midi_pkg::*;
(
  input  logic [7:0] rx_data,
  output logic       is_data,
  output logic       is_voice,
  output logic       is_common,
  output logic       is_rt,
  output logic       needs_two_data
);

  // Classify by value range; needs_two_data is only meaningful for voice status bytes
  always_comb begin
    is_data        = ~rx_data[7];
    is_rt          = (rx_data >= REALTIME_BASE);
    is_common      = (rx_data >= COMMON_BASE) && (rx_data < REALTIME_BASE);
    is_voice       = rx_data[7] && (rx_data < COMMON_BASE);
    needs_two_data = (rx_data[7:4] != PROG) && (rx_data[7:4] != CH_AT);
  end

endmodule

// File: rtl/midi_note_parser.sv
// rtl/midi_note_parser.sv - channel-filtered MIDI Note On/Off decoder with running status
module midi_note_parser
  import midi_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       note_on,
  output logic       note_off,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       err
);

  localparam logic [3:0] CHAN = 4'(CHANNEL);
  localparam logic       OMNI_EN = (OMNI != 0);

  logic is_data, is_voice, is_common, is_rt, needs_two_data;

  midi_byte_classify u_classify (
    .rx_data        (rx_data),
    .is_data        (is_data),
    .is_voice       (is_voice),
    .is_common      (is_common),
    .is_rt          (is_rt),
    .needs_two_data (needs_two_data)
  );

  parse_state_e state_q, state_d;
  logic [3:0]   run_type_q, run_type_d;
  logic         run_two_q, run_two_d;
  logic         match_q, match_d;
  logic [6:0]   d1_q, d1_d;
  logic [6:0]   held_q, held_d;
  logic [6:0]   note_q, note_d;
  logic [6:0]   velocity_q, velocity_d;
  logic         gate_q, gate_d;
  logic         note_on_q, note_on_d;
  logic         note_off_q, note_off_d;
  logic         err_q, err_d;

  // Register all parser and output state; reset clears everything
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      run_type_q <= 4'h0;
      run_two_q  <= 1'b0;
      match_q    <= 1'b0;
      d1_q       <= 7'h00;
      held_q     <= 7'h00;
      note_q     <= 7'h00;
      velocity_q <= 7'h00;
      gate_q     <= 1'b0;
      note_on_q  <= 1'b0;
      note_off_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_type_q <= run_type_d;
      run_two_q  <= run_two_d;
      match_q    <= match_d;
      d1_q       <= d1_d;
      held_q     <= held_d;
      note_q     <= note_d;
      velocity_q <= velocity_d;
      gate_q     <= gate_d;
      note_on_q  <= note_on_d;
      note_off_q <= note_off_d;
      err_q      <= err_d;
    end
  end

  // Next-state: byte dispatch, running status, message completion and note tracking
  always_comb begin
    state_d    = state_q;
    run_type_d = run_type_q;
    run_two_d  = run_two_q;
    match_d    = match_q;
    d1_d       = d1_q;
    held_d     = held_q;
    note_d     = note_q;
    velocity_d = velocity_q;
    gate_d     = gate_q;
    note_on_d  = 1'b0;
    note_off_d = 1'b0;
    err_d      = 1'b0;

    if (rx_valid) begin
      if (is_rt) begin
        // Realtime bytes are transparent to message parsing
      end else if (is_common) begin
        // Only a SysEx start swallows following data; other common bytes
        // (including the F7 terminator) leave the parser with no status.
        run_type_d = 4'h0;
        run_two_d  = 1'b0;
        match_d    = 1'b0;
        state_d    = (rx_data == COMMON_BASE) ? SYSEX : IDLE;
      end else if (is_voice) begin
        run_type_d = rx_data[7:4];
        run_two_d  = needs_two_data;
        match_d    = OMNI_EN || (rx_data[3:0] == CHAN);
        state_d    = WAIT_D1;
      end else if (is_data) begin
        unique case (state_q)
          IDLE: err_d = 1'b1;
          WAIT_D1: begin
            d1_d = rx_data[6:0];
            if (run_two_q) state_d = WAIT_D2;
          end
          WAIT_D2: begin
            state_d = WAIT_D1;
            if (match_q) begin
              if ((run_type_q == NOTE_ON) && (rx_data[6:0] != 7'h00)) begin
                note_d     = d1_q;
                velocity_d = rx_data[6:0];
                held_d     = d1_q;
                gate_d     = 1'b1;
                note_on_d  = 1'b1;
              end else if ((run_type_q == NOTE_OFF) || (run_type_q == NOTE_ON)) begin
                if (gate_q && (d1_q == held_q)) begin
                  note_d     = d1_q;
                  velocity_d = rx_data[6:0];
                  gate_d     = 1'b0;
                  note_off_d = 1'b1;
                end
              end
            end
          end
          SYSEX: ;
          default: ;
        endcase
      end
    end
  end

  assign note_on  = note_on_q;
  assign note_off = note_off_q;
  assign note     = note_q;
  assign velocity = velocity_q;
  assign gate     = gate_q;
  assign err      = err_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// tb/tb_midi_note_parser.sv - self-checking bench for midi_note_parser
module tb_midi_note_parser;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic       on0, off0, err0, gate0;
  logic [6:0] note0, vel0;
  logic       on1, off1, err1, gate1;
  logic [6:0] note1, vel1;

  always #5 clk = ~clk;

  midi_note_parser #(.CHANNEL(0), .OMNI(0)) dut (
    .clk(clk), .rst_b(rst_b), .rx_data(rx_data), .rx_valid(rx_valid),
    .note_on(on0), .note_off(off0), .note(note0), .velocity(vel0),
    .gate(gate0), .err(err0)
  );

  midi_note_parser #(.CHANNEL(0), .OMNI(1)) dut_omni (
    .clk(clk), .rst_b(rst_b), .rx_data(rx_data), .rx_valid(rx_valid),
    .note_on(on1), .note_off(off1), .note(note1), .velocity(vel1),
    .gate(gate1), .err(err1)
  );

  // Expected observation: {on, off, err, note, velocity, gate, omni_on}
  typedef logic [18:0] obs_t;

  typedef struct packed {
    logic       v;
    logic [7:0] d;
    logic       on;
    logic       off;
    logic       er;
    logic [6:0] n;
    logic [6:0] vel;
    logic       g;
    logic       on1;
  } vec_t;

  vec_t tbl[$];
  obs_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic on,
                              input logic off, input logic er, input logic [6:0] n,
                              input logic [6:0] vel, input logic g, input logic o1);
    vec_t t;
    t.v = v; t.d = d; t.on = on; t.off = off; t.er = er;
    t.n = n; t.vel = vel; t.g = g; t.on1 = o1;
    return t;
  endfunction

  function automatic obs_t observe();
    return {on0, off0, err0, note0, vel0, gate0, on1};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got on/off/err/note/vel/gate/omni_on=%b/%b/%b/%h/%h/%b/%b want %b/%b/%b/%h/%h/%b/%b",
                  name, got[18], got[17], got[16], got[15:9], got[8:2], got[1], got[0],
                  want[18], want[17], want[16], want[15:9], want[8:2], want[1], want[0]);
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge
  task automatic apply(input string name, input vec_t t);
    obs_t want;
    @(negedge clk);
    rx_valid = t.v;
    rx_data  = t.d;
    exp_q.push_back({t.on, t.off, t.er, t.n, t.vel, t.g, t.on1});
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      want = exp_q.pop_front();
      check(name, observe(), want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_b = 1'b0;
    rx_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_total++;
    if ({on0, off0, err0, note0, vel0, gate0, on1, off1, err1, note1, vel1, gate1} === '0) n_pass++;
    else $display("FAIL reset_zero: got dut=%b%b%b %h %h %b omni=%b%b%b %h %h %b want all 0",
                  on0, off0, err0, note0, vel0, gate0, on1, off1, err1, note1, vel1, gate1);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    // Basic note on/off
    tbl.push_back(mk(1, 8'h90, 0,0,0, 7'h00, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h00, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h64, 1,0,0, 7'h3C, 7'h64, 1, 1));
    tbl.push_back(mk(1, 8'h80, 0,0,0, 7'h3C, 7'h64, 1, 0));
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h3C, 7'h64, 1, 0));
    tbl.push_back(mk(1, 8'h40, 0,1,0, 7'h3C, 7'h40, 0, 0));
    // Running status, retrigger, release of a non-held note ignored
    tbl.push_back(mk(1, 8'h90, 0,0,0, 7'h3C, 7'h40, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h3C, 7'h40, 0, 0));
    tbl.push_back(mk(1, 8'h64, 1,0,0, 7'h3C, 7'h64, 1, 1));
    tbl.push_back(mk(1, 8'h40, 0,0,0, 7'h3C, 7'h64, 1, 0));
    tbl.push_back(mk(1, 8'h50, 1,0,0, 7'h40, 7'h50, 1, 1));
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h40, 7'h50, 1, 0));
    tbl.push_back(mk(1, 8'h00, 0,0,0, 7'h40, 7'h50, 1, 0));
    tbl.push_back(mk(1, 8'h80, 0,0,0, 7'h40, 7'h50, 1, 0));
    tbl.push_back(mk(1, 8'h40, 0,0,0, 7'h40, 7'h50, 1, 0));
    tbl.push_back(mk(1, 8'h00, 0,1,0, 7'h40, 7'h00, 0, 0));
    // Channel filter: channel 1 only seen by the omni instance
    tbl.push_back(mk(1, 8'h91, 0,0,0, 7'h40, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h40, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h64, 0,0,0, 7'h40, 7'h00, 0, 1));
    tbl.push_back(mk(1, 8'h81, 0,0,0, 7'h40, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h40, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0,0,0, 7'h40, 7'h00, 0, 0));
    // Realtime interleaved
    tbl.push_back(mk(1, 8'h90, 0,0,0, 7'h40, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'hF8, 0,0,0, 7'h40, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h40, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'hF8, 0,0,0, 7'h40, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'hFE, 0,0,0, 7'h40, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h64, 1,0,0, 7'h3C, 7'h64, 1, 1));
    tbl.push_back(mk(1, 8'hF8, 0,0,0, 7'h3C, 7'h64, 1, 0));
    tbl.push_back(mk(0, 8'h55, 0,0,0, 7'h3C, 7'h64, 1, 0));
    // Note On with velocity 0 releases the held note
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h3C, 7'h64, 1, 0));
    tbl.push_back(mk(1, 8'h00, 0,1,0, 7'h3C, 7'h00, 0, 0));
    // SysEx swallows data; after F7 a data byte is an error
    tbl.push_back(mk(1, 8'hF0, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h7F, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'hF7, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 0,0,1, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0,0,0, 7'h3C, 7'h00, 0, 0));
    // Aborted note followed by CC, then program change with running status
    tbl.push_back(mk(1, 8'h90, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h3C, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'hB0, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h07, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h7F, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'hC0, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h05, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h06, 0,0,0, 7'h3C, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h64, 0,0,0, 7'h3C, 7'h00, 0, 0));

    do_reset();

    foreach (tbl[i]) apply($sformatf("vec%0d_byte%h", i, tbl[i].d), tbl[i]);

    // Data byte right after reset raises err only
    do_reset();
    apply("post_reset_data", mk(1, 8'h3C, 0,0,1, 7'h00, 7'h00, 0, 0));
    apply("post_reset_err_clears", mk(0, 8'h00, 0,0,0, 7'h00, 7'h00, 0, 0));

    // Reset between status and first data byte discards the message
    apply("pre_reset_on", mk(1, 8'h90, 0,0,0, 7'h00, 7'h00, 0, 0));
    apply("pre_reset_d1", mk(1, 8'h3C, 0,0,0, 7'h00, 7'h00, 0, 0));
    apply("pre_reset_d2", mk(1, 8'h64, 1,0,0, 7'h3C, 7'h64, 1, 1));
    apply("mid_status",   mk(1, 8'h90, 0,0,0, 7'h3C, 7'h64, 1, 0));
    do_reset();
    apply("mid_reset_d1", mk(1, 8'h3C, 0,0,1, 7'h00, 7'h00, 0, 0));
    apply("mid_reset_d2", mk(1, 8'h64, 0,0,1, 7'h00, 7'h00, 0, 0));
    apply("mid_reset_idle", mk(0, 8'h00, 0,0,0, 7'h00, 7'h00, 0, 0));

    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
